fetch_stage: RTL

Instruction fetch stage for the MIPS-subset core. Holds the program counter, drives the instruction ROM address, and registers the returned word into the IF/ID pipeline register. It also redirects fetch on branches and jumps resolved in decode, and supports stall and flush. The instruction ROM is purely combinational: the word for pc_out is valid in the same cycle.

---
 rtl/fetch_stage.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, ROM addressing and the IF/ID pipeline register.
// Decode-resolved jumps and branches redirect fetch and squash IF/ID, costing one bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_seq_s;
  logic [31:0] branch_target_s;
  logic [31:0] jump_target_s;
  logic        take_jump_s;
  logic        take_branch_s;

  // Redirects only make sense for a real instruction sitting in IF/ID.
  assign take_jump_s     = jump & ifid_valid_q;
  assign take_branch_s   = branch_taken & ifid_valid_q;
  assign pc_seq_s        = pc_q + PC_STEP;
  assign branch_target_s = ifid_pc4_q + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_target_s   = {ifid_pc4_q[31:28], jump_index, 2'b00};

  // Next-state selection: jump, then branch, then stall, then sequential fetch.
  always_comb begin
    pc_d          = pc_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_inst_d   = ifid_inst_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    if (take_jump_s) begin
      pc_d         = jump_target_s;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_inst_d  = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end else if (take_branch_s) begin
      pc_d         = branch_target_s;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_inst_d  = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      pc_d          = pc_q;
      fetch_count_d = fetch_count_q;
    end else begin
      pc_d          = pc_seq_s;
      ifid_pc4_d    = pc_seq_s;
      ifid_inst_d   = inst_in;
      ifid_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ifid_pc4_q    <= 32'h0000_0000;
      ifid_inst_q   <= 32'h0000_0000;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_inst_q   <= ifid_inst_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_out      = pc_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_inst   = ifid_inst_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_count = fetch_count_q;

endmodule
